// File: rtl/isa_types.sv
`timescale 1ns/1ps
// isa_types
// Shared ISA widths used by the fetch stage and its neighbours.
//   XLEN : width of addresses and the program counter
//   ILEN : width of one instruction word
package isa_types;
    parameter int XLEN = 32;
    parameter int ILEN = 32;
endpackage

// File: rtl/instruction_fetch.sv
`timescale 1ns/1ps
// instruction_fetch
// Fetch stage that feeds the instruction decoder. It holds the program
// counter, issues one word-aligned read at a time to instruction memory,
// and hands each fetched word plus its PC to decode. Redirects from
// execute replace the PC at any time; a response belonging to a request
// issued before the redirect is swallowed. A misaligned redirect target
// halts fetching until an aligned redirect arrives.
//
// Ports:
//   clk              system clock
//   reset_n          asynchronous active-low reset
//   imem_req_valid   request valid towards instruction memory
//   imem_req_ready   memory accepts the request this cycle
//   imem_req_addr    byte address of the request (always word aligned)
//   imem_resp_valid  response valid; one per accepted request
//   imem_resp_data   fetched instruction word
//   instr_valid      instruction valid towards decode
//   instr_ready      decode consumes the instruction this cycle
//   instr_bits       instruction word for decode
//   instr_pc         PC of instr_bits
//   redirect_valid   load a new PC this cycle
//   redirect_pc      redirect target
//   fetch_fault      misaligned redirect target; fetching halted
//
// RESET_PC must be a multiple of 4.
module instruction_fetch
    import isa_types::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [ILEN-1:0] imem_resp_data,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [ILEN-1:0] instr_bits,
    output logic [XLEN-1:0] instr_pc,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            fetch_fault
);

    localparam logic [2:0] ST_REQ   = 3'd0;
    localparam logic [2:0] ST_WAIT  = 3'd1;
    localparam logic [2:0] ST_HOLD  = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;
    localparam logic [2:0] ST_FAULT = 3'd4;

    logic [2:0]      state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            instr_valid_q, instr_valid_d;
    logic [ILEN-1:0] instr_bits_q, instr_bits_d;
    logic [XLEN-1:0] instr_pc_q, instr_pc_d;
    logic            fault_pending_q, fault_pending_d;

    logic            req_fire;
    logic            redirect_misaligned;
    logic            resp_outstanding;

    // The request is gated by reset_n so nothing is offered to memory while
    // reset is held, even though the state register already sits in REQ.
    assign imem_req_valid = reset_n & (state_q == ST_REQ);
    assign imem_req_addr  = pc_q;
    assign instr_valid    = instr_valid_q;
    assign instr_bits     = instr_bits_q;
    assign instr_pc       = instr_pc_q;
    assign fetch_fault    = (state_q == ST_FAULT);

    assign req_fire            = imem_req_valid & imem_req_ready;
    assign redirect_misaligned = (redirect_pc[1:0] != 2'b00);

    // After a redirect, a response is still owed to us if a request is
    // accepted this cycle, or we were already waiting and it has not come.
    always_comb begin
        resp_outstanding = 1'b0;
        case (state_q)
            ST_REQ:   resp_outstanding = req_fire;
            ST_WAIT:  resp_outstanding = ~imem_resp_valid;
            ST_DRAIN: resp_outstanding = ~imem_resp_valid;
            default:  resp_outstanding = 1'b0;
        endcase
    end

    // Next-state logic. A redirect overrides whatever the current state
    // would do; otherwise the single outstanding request walks through
    // REQ -> WAIT -> HOLD and back.
    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        instr_valid_d   = instr_valid_q;
        instr_bits_d    = instr_bits_q;
        instr_pc_d      = instr_pc_q;
        fault_pending_d = fault_pending_q;

        if (redirect_valid) begin
            pc_d            = redirect_pc;
            instr_valid_d   = 1'b0;
            fault_pending_d = redirect_misaligned;
            if (resp_outstanding) begin
                state_d = ST_DRAIN;
            end else if (redirect_misaligned) begin
                state_d = ST_FAULT;
            end else begin
                state_d = ST_REQ;
            end
        end else begin
            case (state_q)
                ST_REQ: begin
                    if (req_fire) begin
                        state_d = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (imem_resp_valid) begin
                        instr_bits_d  = imem_resp_data;
                        instr_pc_d    = pc_q;
                        instr_valid_d = 1'b1;
                        pc_d          = pc_q + XLEN'(4);
                        state_d       = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (instr_ready) begin
                        instr_valid_d = 1'b0;
                        state_d       = ST_REQ;
                    end
                end
                ST_DRAIN: begin
                    if (imem_resp_valid) begin
                        state_d = fault_pending_q ? ST_FAULT : ST_REQ;
                    end
                end
                ST_FAULT: begin
                    state_d = ST_FAULT;
                end
                default: begin
                    state_d       = ST_REQ;
                    instr_valid_d = 1'b0;
                end
            endcase
        end
    end

    // State registers; reset abandons any in-flight response because the
    // memory side is reset alongside this block.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= ST_REQ;
            pc_q            <= RESET_PC;
            instr_valid_q   <= 1'b0;
            instr_bits_q    <= '0;
            instr_pc_q      <= '0;
            fault_pending_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            pc_q            <= pc_d;
            instr_valid_q   <= instr_valid_d;
            instr_bits_q    <= instr_bits_d;
            instr_pc_q      <= instr_pc_d;
            fault_pending_q <= fault_pending_d;
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
`timescale 1ns/1ps
// tb_instruction_fetch
// Directed bench for the fetch stage. A behavioural instruction memory
// answers accepted requests after a programmable latency; expected
// request addresses and delivered instructions are queued by the
// stimulus and popped by independent monitors.
module tb_instruction_fetch;
    import isa_types::*;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_resp_valid;
    logic [ILEN-1:0] imem_resp_data;
    logic            instr_valid;
    logic            instr_ready;
    logic [ILEN-1:0] instr_bits;
    logic [XLEN-1:0] instr_pc;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            fetch_fault;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] bits;
    } instr_t;

    logic [31:0] exp_req_q[$];
    instr_t      exp_instr_q[$];

    int compared   = 0;
    int mismatched = 0;
    int cycle      = 0;

    logic        mem_ready;
    int          mem_latency;
    logic [31:0] stale_addr;
    logic        gap_check;

    instruction_fetch #(.RESET_PC(32'h0000_0100)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .instr_bits      (instr_bits),
        .instr_pc        (instr_pc),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .fetch_fault     (fetch_fault)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    assign imem_req_ready = mem_ready;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // One-cycle redirect pulse, launched just after a rising edge.
    task automatic applyStimulus(input logic [31:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        nextCycle();
        redirect_valid = 1'b0;
    endtask

    // Wait for every queued request to be accepted, then stall memory so
    // the stage cannot run ahead of the next test.
    task automatic waitReqDrain(input string name);
        int n = 0;
        while (exp_req_q.size() != 0 && n < 200) begin
            nextCycle();
            n++;
        end
        if (exp_req_q.size() != 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL %s_req_timeout: %0d requests still expected", name, exp_req_q.size());
            exp_req_q.delete();
        end
        mem_ready = 1'b0;
    endtask

    task automatic waitInstrDrain(input string name);
        int n = 0;
        while (exp_instr_q.size() != 0 && n < 200) begin
            nextCycle();
            n++;
        end
        if (exp_instr_q.size() != 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL %s_instr_timeout: %0d instructions still expected", name, exp_instr_q.size());
            exp_instr_q.delete();
        end
    endtask

    task automatic pushInstr(input logic [31:0] pc, input logic [31:0] bits);
        instr_t e;
        e.pc   = pc;
        e.bits = bits;
        exp_instr_q.push_back(e);
    endtask

    task automatic checkReset(input string name);
        checkOutput({name, "_req_valid"},   {31'b0, imem_req_valid}, 32'h0);
        checkOutput({name, "_instr_valid"}, {31'b0, instr_valid},    32'h0);
        checkOutput({name, "_instr_bits"},  instr_bits,              32'h0);
        checkOutput({name, "_instr_pc"},    instr_pc,                32'h0);
        checkOutput({name, "_fetch_fault"}, {31'b0, fetch_fault},    32'h0);
    endtask

    // Behavioural memory: drives its response at falling edges so the DUT
    // samples it cleanly on the following rising edge. Latency N means the
    // response is valid N cycles after the accepting edge's cycle.
    initial begin
        logic        busy;
        int          cnt;
        logic [31:0] addr;
        busy = 1'b0;
        cnt  = 0;
        addr = '0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        forever begin
            @(negedge clk);
            imem_resp_valid = 1'b0;
            if (!reset_n) begin
                busy = 1'b0;
            end else if (busy) begin
                cnt--;
                if (cnt == 0) begin
                    imem_resp_valid = 1'b1;
                    imem_resp_data  = (addr == stale_addr) ? 32'hDEAD_BEEF : {16'hC0DE, addr[15:0]};
                    busy            = 1'b0;
                end
            end else if (imem_req_valid && mem_ready) begin
                busy = 1'b1;
                cnt  = mem_latency;
                addr = imem_req_addr;
            end
        end
    end

    // Request monitor plus interface invariants.
    initial begin
        int last_req_cycle;
        last_req_cycle = -1;
        forever begin
            @(negedge clk);
            if (!gap_check) last_req_cycle = -1;
            checkOutput("req_instr_exclusive", {31'b0, imem_req_valid & instr_valid}, 32'h0);
            if (imem_req_valid) begin
                checkOutput("req_aligned", {30'b0, imem_req_addr[1:0]}, 32'h0);
            end
            if (reset_n && imem_req_valid && imem_req_ready) begin
                if (exp_req_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL req_unexpected: got addr %h expected no request", imem_req_addr);
                end else begin
                    checkOutput("req_addr", imem_req_addr, exp_req_q.pop_front());
                end
                if (gap_check) begin
                    if (last_req_cycle >= 0) begin
                        checkOutput("req_gap", cycle - last_req_cycle, 32'd3);
                    end
                    last_req_cycle = cycle;
                end
            end
        end
    end

    // Instruction monitor: every decode handshake must match the head of
    // the expected-instruction queue.
    initial begin
        instr_t e;
        forever begin
            @(negedge clk);
            if (reset_n && instr_valid && instr_ready && !redirect_valid) begin
                if (exp_instr_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL instr_unexpected: got pc %h bits %h expected none", instr_pc, instr_bits);
                end else begin
                    e = exp_instr_q.pop_front();
                    checkOutput("instr_pc", instr_pc, e.pc);
                    checkOutput("instr_bits", instr_bits, e.bits);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        reset_n        = 1'b0;
        mem_ready      = 1'b0;
        mem_latency    = 1;
        stale_addr     = 32'hFFFF_FFFF;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        gap_check      = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        $display("[TB] reset state");
        checkReset("reset");

        $display("[TB] back-to-back fetch from RESET_PC");
        mem_ready   = 1'b1;
        instr_ready = 1'b1;
        gap_check   = 1'b1;
        exp_req_q.push_back(32'h0000_0100);
        exp_req_q.push_back(32'h0000_0104);
        exp_req_q.push_back(32'h0000_0108);
        pushInstr(32'h0000_0100, 32'hC0DE_0100);
        pushInstr(32'h0000_0104, 32'hC0DE_0104);
        pushInstr(32'h0000_0108, 32'hC0DE_0108);
        reset_n = 1'b1;
        waitReqDrain("t1");
        waitInstrDrain("t1");
        gap_check = 1'b0;

        $display("[TB] long latency and decode back-pressure");
        mem_latency = 4;
        instr_ready = 1'b0;
        exp_req_q.push_back(32'h0000_010C);
        pushInstr(32'h0000_010C, 32'hC0DE_010C);
        mem_ready = 1'b1;
        n = 0;
        while (!instr_valid && n < 20) begin
            nextCycle();
            n++;
        end
        checkOutput("hold_reached", {31'b0, instr_valid}, 32'h1);
        for (int i = 0; i < 5; i++) begin
            checkOutput("hold_valid", {31'b0, instr_valid}, 32'h1);
            checkOutput("hold_bits", instr_bits, 32'hC0DE_010C);
            checkOutput("hold_pc", instr_pc, 32'h0000_010C);
            checkOutput("hold_no_req", {31'b0, imem_req_valid}, 32'h0);
            nextCycle();
        end
        mem_ready   = 1'b0;
        instr_ready = 1'b1;
        waitInstrDrain("t2");
        exp_req_q.delete();

        $display("[TB] redirect while waiting, stale response dropped");
        mem_latency = 3;
        stale_addr  = 32'h0000_0110;
        exp_req_q.push_back(32'h0000_0110);
        exp_req_q.push_back(32'h0000_0200);
        pushInstr(32'h0000_0200, 32'hC0DE_0200);
        mem_ready = 1'b1;
        nextCycle();
        applyStimulus(32'h0000_0200);
        waitReqDrain("t3");
        waitInstrDrain("t3");

        $display("[TB] redirect coinciding with response");
        mem_latency = 2;
        exp_req_q.push_back(32'h0000_0204);
        exp_req_q.push_back(32'h0000_0300);
        pushInstr(32'h0000_0300, 32'hC0DE_0300);
        mem_ready = 1'b1;
        nextCycle();
        nextCycle();
        applyStimulus(32'h0000_0300);
        waitReqDrain("t4");
        waitInstrDrain("t4");

        $display("[TB] misaligned redirect from idle request");
        applyStimulus(32'h0000_0202);
        mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checkOutput("fault_set", {31'b0, fetch_fault}, 32'h1);
            checkOutput("fault_no_req", {31'b0, imem_req_valid}, 32'h0);
            checkOutput("fault_no_instr", {31'b0, instr_valid}, 32'h0);
            nextCycle();
        end
        exp_req_q.push_back(32'h0000_0400);
        pushInstr(32'h0000_0400, 32'hC0DE_0400);
        applyStimulus(32'h0000_0400);
        checkOutput("fault_cleared", {31'b0, fetch_fault}, 32'h0);
        waitReqDrain("t5");
        waitInstrDrain("t5");

        $display("[TB] misaligned redirect with response outstanding");
        mem_latency = 3;
        exp_req_q.push_back(32'h0000_0404);
        mem_ready = 1'b1;
        nextCycle();
        applyStimulus(32'h0000_0123);
        checkOutput("drain_no_fault_yet", {31'b0, fetch_fault}, 32'h0);
        n = 0;
        while (!fetch_fault && n < 20) begin
            nextCycle();
            n++;
        end
        checkOutput("fault_after_drain", {31'b0, fetch_fault}, 32'h1);
        checkOutput("fault_after_drain_no_req", {31'b0, imem_req_valid}, 32'h0);
        exp_req_q.push_back(32'h0000_0500);
        pushInstr(32'h0000_0500, 32'hC0DE_0500);
        applyStimulus(32'h0000_0500);
        waitReqDrain("t5b");
        waitInstrDrain("t5b");

        $display("[TB] PC wrap and reset during WAIT");
        mem_latency = 3;
        exp_req_q.push_back(32'hFFFF_FFFC);
        exp_req_q.push_back(32'h0000_0000);
        pushInstr(32'hFFFF_FFFC, 32'hC0DE_FFFC);
        applyStimulus(32'hFFFF_FFFC);
        mem_ready = 1'b1;
        waitReqDrain("t6");
        waitInstrDrain("t6");
        reset_n = 1'b0;
        #1;
        checkReset("midreset");
        mem_latency = 1;
        exp_req_q.push_back(32'h0000_0100);
        pushInstr(32'h0000_0100, 32'hC0DE_0100);
        mem_ready = 1'b1;
        nextCycle();
        checkReset("midreset_held");
        reset_n = 1'b1;
        waitReqDrain("t7");
        waitInstrDrain("t7");
        repeat (4) nextCycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
